prf_rat_multi: RTL and testbench

- Next-generation physical register file with a rename alias table (RAT).
- Renames up to ALLOC_WIDTH destinations per cycle with intra-group dependency resolution.
- Keeps a retirement map alongside the speculative map and reclaims up to RETIRE_WIDTH old pdsts per cycle.
- Recovers from a pipeline flush by restoring the speculative map and free list from retired state. Sits between decode/rename and the RS/execute write-back.

---
 rtl/prf_rat_multi.sv | 184 ++++++++++++++++++
 tb/tb_prf_rat_multi.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prf_rat_multi.sv
// Physical register file with speculative/retirement rename maps, free/pending lists and flush recovery.
// Optional PRF_ZERO_REG_EN: GPR 0 is pinned to p0 (never renamed, never written, always reads 0).
module prf_rat_multi #(
    parameter int NUM_ENTRIES    = 64,
    parameter int NUM_ARCH       = 32,
    parameter int ALLOC_WIDTH    = 2,
    parameter int RETIRE_WIDTH   = 2,
    parameter int NUM_MAP_READS  = 4,
    parameter int NUM_REG_READS  = 4,
    parameter int NUM_REG_WRITES = 2,
    parameter int DATA_W         = 64,
    localparam int PW = $clog2(NUM_ENTRIES),
    localparam int AW = $clog2(NUM_ARCH)
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [ALLOC_WIDTH-1:0]                       alloc_en_rn0,
    input  logic [ALLOC_WIDTH-1:0][AW-1:0]               alloc_gpr_rn0,
    output logic [ALLOC_WIDTH-1:0][PW-1:0]               pdst_rn1,
    output logic [ALLOC_WIDTH-1:0][PW-1:0]               pdst_old_rn1,
    output logic                                         stall_rn0,
    input  logic [NUM_MAP_READS-1:0][AW-1:0]             rdmap_gpr_rd0,
    output logic [NUM_MAP_READS-1:0][PW-1:0]             rdmap_psrc_rd1,
    output logic [NUM_MAP_READS-1:0]                     rdmap_pend_rd1,
    input  logic [NUM_REG_WRITES-1:0]                    wr_en_ro0,
    input  logic [NUM_REG_WRITES-1:0][PW-1:0]            wr_pdst_ro0,
    input  logic [NUM_REG_WRITES-1:0][DATA_W-1:0]        wr_data_ro0,
    input  logic [NUM_REG_READS-1:0][PW-1:0]             rd_psrc_rd0,
    output logic [NUM_REG_READS-1:0][DATA_W-1:0]         rd_data_rd1,
    input  logic [RETIRE_WIDTH-1:0]                      ret_en_rb1,
    input  logic [RETIRE_WIDTH-1:0][AW-1:0]              ret_gpr_rb1,
    input  logic [RETIRE_WIDTH-1:0][PW-1:0]              ret_pdst_rb1,
    input  logic [RETIRE_WIDTH-1:0][PW-1:0]              ret_pdst_old_rb1,
    input  logic                                         flush,
    output logic                                         recovering
);

`ifdef PRF_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_RECOVER} state_t;

    state_t                                   state_q, state_d;
    logic [NUM_ARCH-1:0][PW-1:0]              map_q, map_d;
    logic [NUM_ARCH-1:0][PW-1:0]              rmap_q, rmap_d;
    logic [NUM_ENTRIES-1:0]                   free_list_q, free_list_d;
    logic [NUM_ENTRIES-1:0]                   pend_list_q, pend_list_d;
    logic [NUM_ENTRIES-1:0][DATA_W-1:0]       prf_q, prf_d;
    logic [ALLOC_WIDTH-1:0][PW-1:0]           pdst_q, pdst_d;
    logic [ALLOC_WIDTH-1:0][PW-1:0]           pdst_old_q, pdst_old_d;
    logic [NUM_MAP_READS-1:0][PW-1:0]         psrc_q, psrc_d;
    logic [NUM_MAP_READS-1:0]                 rdpend_q, rdpend_d;
    logic [NUM_REG_READS-1:0][DATA_W-1:0]     rd_data_q, rd_data_d;

    logic [NUM_ENTRIES-1:0]                   avail, alloc_mask, reclaim_mask, wr_mask, used_mask;
    logic [ALLOC_WIDTH-1:0]                   slot_go;
    logic                                     alloc_go;
    int                                       free_cnt;

    always_comb begin
        free_cnt = 0;
        for (int e = 0; e < NUM_ENTRIES; e++) free_cnt += int'(free_list_q[e]);
        stall_rn0 = (free_cnt < ALLOC_WIDTH) || flush || (state_q != S_IDLE);
        alloc_go  = !stall_rn0;

        rmap_d       = rmap_q;
        reclaim_mask = '0;
        for (int r = 0; r < RETIRE_WIDTH; r++) begin
            if (ret_en_rb1[r]) begin
                rmap_d[ret_gpr_rb1[r]]           = ret_pdst_rb1[r];
                reclaim_mask[ret_pdst_old_rb1[r]] = 1'b1;
            end
        end
        if (ZERO_EN) reclaim_mask[0] = 1'b0;

        // Slots consume free entries lowest-first; a later slot sees earlier same-GPR slots as its old mapping.
        avail      = free_list_q;
        alloc_mask = '0;
        map_d      = map_q;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            pdst_d[k]     = '0;
            pdst_old_d[k] = '0;
            slot_go[k]    = alloc_go && alloc_en_rn0[k] && !(ZERO_EN && alloc_gpr_rn0[k] == '0);
            if (slot_go[k]) begin
                for (int e = NUM_ENTRIES - 1; e >= 0; e--)
                    if (avail[e]) pdst_d[k] = PW'(e);
                avail[pdst_d[k]]      = 1'b0;
                alloc_mask[pdst_d[k]] = 1'b1;
                pdst_old_d[k]         = map_q[alloc_gpr_rn0[k]];
                for (int j = 0; j < k; j++)
                    if (slot_go[j] && alloc_gpr_rn0[j] == alloc_gpr_rn0[k]) pdst_old_d[k] = pdst_d[j];
                map_d[alloc_gpr_rn0[k]] = pdst_d[k];
            end
        end
        if (flush) map_d = rmap_d;

        prf_d   = prf_q;
        wr_mask = '0;
        for (int w = 0; w < NUM_REG_WRITES; w++) begin
            if (wr_en_ro0[w] && !(ZERO_EN && wr_pdst_ro0[w] == '0)) begin
                prf_d[wr_pdst_ro0[w]]   = wr_data_ro0[w];
                wr_mask[wr_pdst_ro0[w]] = 1'b1;
            end
        end

        if (flush) pend_list_d = '0;
        else       pend_list_d = (pend_list_q & ~wr_mask) | alloc_mask;

        // Recovery rebuilds the free list as everything not held by the retirement map.
        used_mask = '0;
        for (int g = 0; g < NUM_ARCH; g++) used_mask[rmap_d[g]] = 1'b1;
        if (state_q == S_RECOVER) free_list_d = ~used_mask;
        else                      free_list_d = (free_list_q | reclaim_mask) & ~alloc_mask;
        if (ZERO_EN) free_list_d[0] = 1'b0;

        for (int i = 0; i < NUM_MAP_READS; i++) begin
            psrc_d[i]   = map_q[rdmap_gpr_rd0[i]];
            rdpend_d[i] = pend_list_d[map_q[rdmap_gpr_rd0[i]]];
            if (ZERO_EN && rdmap_gpr_rd0[i] == '0) begin
                psrc_d[i]   = '0;
                rdpend_d[i] = 1'b0;
            end
        end

        // prf_d already carries same-cycle writes with the highest port last, giving the bypass.
        for (int r = 0; r < NUM_REG_READS; r++) rd_data_d[r] = prf_d[rd_psrc_rd0[r]];

        state_d = state_q;
        case (state_q)
            S_IDLE:    if (flush) state_d = S_RECOVER;
            S_RECOVER: state_d = flush ? S_RECOVER : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            for (int g = 0; g < NUM_ARCH; g++) begin
                map_q[g]  <= PW'(g);
                rmap_q[g] <= PW'(g);
            end
            free_list_q <= {{(NUM_ENTRIES - NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
            pend_list_q <= '0;
            prf_q       <= '0;
            pdst_q      <= '0;
            pdst_old_q  <= '0;
            psrc_q      <= '0;
            rdpend_q    <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            map_q       <= map_d;
            rmap_q      <= rmap_d;
            free_list_q <= free_list_d;
            pend_list_q <= pend_list_d;
            prf_q       <= prf_d;
            pdst_q      <= pdst_d;
            pdst_old_q  <= pdst_old_d;
            psrc_q      <= psrc_d;
            rdpend_q    <= rdpend_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int a = 0; a < NUM_REG_WRITES; a++)
                for (int b = a + 1; b < NUM_REG_WRITES; b++)
                    assert (!(wr_en_ro0[a] && wr_en_ro0[b] && wr_pdst_ro0[a] == wr_pdst_ro0[b]));
        end
    end

    assign pdst_rn1       = pdst_q;
    assign pdst_old_rn1   = pdst_old_q;
    assign rdmap_psrc_rd1 = psrc_q;
    assign rdmap_pend_rd1 = rdpend_q;
    assign rd_data_rd1    = rd_data_q;
    assign recovering     = (state_q == S_RECOVER);

endmodule

// File: tb/tb_prf_rat_multi.sv
// Directed bench for prf_rat_multi: stimulus queues expected outputs tagged with a cycle, a monitor checks them.
module tb_prf_rat_multi;
    localparam int NE = 64, NA = 32, AWD = 2, RWD = 2, NMR = 4, NRR = 4, NRW = 2, DW = 64;
    localparam int PW = 6, AW = 5;
    localparam int K_PDST = 0, K_OLD = 1, K_PSRC = 2, K_PEND = 3, K_RDD = 4, K_STALL = 5, K_RECOV = 6;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [AWD-1:0]             alloc_en;
    logic [AWD-1:0][AW-1:0]     alloc_gpr;
    logic [AWD-1:0][PW-1:0]     pdst_rn1, pdst_old_rn1;
    logic                       stall_rn0;
    logic [NMR-1:0][AW-1:0]     rdmap_gpr;
    logic [NMR-1:0][PW-1:0]     rdmap_psrc;
    logic [NMR-1:0]             rdmap_pend;
    logic [NRW-1:0]             wr_en;
    logic [NRW-1:0][PW-1:0]     wr_pdst;
    logic [NRW-1:0][DW-1:0]     wr_data;
    logic [NRR-1:0][PW-1:0]     rd_psrc;
    logic [NRR-1:0][DW-1:0]     rd_data;
    logic [RWD-1:0]             ret_en;
    logic [RWD-1:0][AW-1:0]     ret_gpr;
    logic [RWD-1:0][PW-1:0]     ret_pdst, ret_pdst_old;
    logic                       flush;
    logic                       recovering;

    prf_rat_multi dut (
        .clk(clk), .reset(reset),
        .alloc_en_rn0(alloc_en), .alloc_gpr_rn0(alloc_gpr),
        .pdst_rn1(pdst_rn1), .pdst_old_rn1(pdst_old_rn1), .stall_rn0(stall_rn0),
        .rdmap_gpr_rd0(rdmap_gpr), .rdmap_psrc_rd1(rdmap_psrc), .rdmap_pend_rd1(rdmap_pend),
        .wr_en_ro0(wr_en), .wr_pdst_ro0(wr_pdst), .wr_data_ro0(wr_data),
        .rd_psrc_rd0(rd_psrc), .rd_data_rd1(rd_data),
        .ret_en_rb1(ret_en), .ret_gpr_rb1(ret_gpr), .ret_pdst_rb1(ret_pdst), .ret_pdst_old_rb1(ret_pdst_old),
        .flush(flush), .recovering(recovering)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        int          idx;
        logic [63:0] val;
    } exp_t;

    exp_t        sbq[$];
    exp_t        keep_q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [63:0] mon_act;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] actual(int kind, int idx);
        case (kind)
            K_PDST:  return 64'(pdst_rn1[idx]);
            K_OLD:   return 64'(pdst_old_rn1[idx]);
            K_PSRC:  return 64'(rdmap_psrc[idx]);
            K_PEND:  return 64'(rdmap_pend[idx]);
            K_RDD:   return rd_data[idx];
            K_STALL: return 64'(stall_rn0);
            default: return 64'(recovering);
        endcase
    endfunction

    function automatic string kname(int kind);
        case (kind)
            K_PDST:  return "pdst";
            K_OLD:   return "pdst_old";
            K_PSRC:  return "psrc";
            K_PEND:  return "pend";
            K_RDD:   return "rd_data";
            K_STALL: return "stall";
            default: return "recovering";
        endcase
    endfunction

    always @(negedge clk) begin
        keep_q.delete();
        foreach (sbq[i]) begin
            if (sbq[i].cyc == cyc) begin
                mon_act = actual(sbq[i].kind, sbq[i].idx);
                total++;
                if (mon_act !== sbq[i].val) begin
                    bad++;
                    $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h", kname(sbq[i].kind), sbq[i].idx,
                             cyc, mon_act, sbq[i].val);
                end
            end else begin
                keep_q.push_back(sbq[i]);
            end
        end
        sbq = keep_q;
    end

    task automatic expect_at(int dly, int kind, int idx, logic [63:0] val);
        exp_t e;
        e.cyc = cyc + dly; e.kind = kind; e.idx = idx; e.val = val;
        sbq.push_back(e);
    endtask

    task automatic idle_in();
        alloc_en = '0; alloc_gpr = '0; rdmap_gpr = '0;
        wr_en = '0; wr_pdst = '0; wr_data = '0; rd_psrc = '0;
        ret_en = '0; ret_gpr = '0; ret_pdst = '0; ret_pdst_old = '0;
        flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic alloc2(int g0, int g1);
        alloc_en = 2'b11;
        alloc_gpr[0] = AW'(g0);
        alloc_gpr[1] = AW'(g1);
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        step();

        // Reset values, then a two-slot rename of distinct GPRs
        do_reset();
        expect_at(0, K_PDST, 0, 0);
        expect_at(0, K_OLD, 1, 0);
        expect_at(0, K_PSRC, 0, 0);
        expect_at(0, K_PEND, 0, 0);
        expect_at(0, K_RDD, 0, 0);
        expect_at(0, K_RECOV, 0, 0);
        alloc2(5, 7);
        expect_at(0, K_STALL, 0, 0);
        expect_at(1, K_PDST, 0, 32);
        expect_at(1, K_PDST, 1, 33);
        expect_at(1, K_OLD, 0, 5);
        expect_at(1, K_OLD, 1, 7);
        step();

        idle_in();
        rdmap_gpr[0] = 5; rdmap_gpr[1] = 7; rdmap_gpr[2] = 6;
        expect_at(1, K_PSRC, 0, 32); expect_at(1, K_PEND, 0, 1);
        expect_at(1, K_PSRC, 1, 33); expect_at(1, K_PEND, 1, 1);
        expect_at(1, K_PSRC, 2, 6);  expect_at(1, K_PEND, 2, 0);
        step();

        // Write-back with same-cycle read bypass and pend clear
        idle_in();
        wr_en[0] = 1'b1; wr_pdst[0] = 32; wr_data[0] = 64'hABCD;
        rd_psrc[0] = 32; rd_psrc[1] = 33; rdmap_gpr[0] = 5;
        expect_at(1, K_RDD, 0, 64'hABCD);
        expect_at(1, K_RDD, 1, 0);
        expect_at(1, K_PSRC, 0, 32);
        expect_at(1, K_PEND, 0, 0);
        step();

        idle_in();
        wr_en[1] = 1'b1; wr_pdst[1] = 33; wr_data[1] = 64'h1234_5678_9ABC_DEF0;
        rd_psrc[2] = 32; rd_psrc[3] = 33; rdmap_gpr[0] = 5; rdmap_gpr[1] = 7;
        expect_at(1, K_RDD, 2, 64'hABCD);
        expect_at(1, K_RDD, 3, 64'h1234_5678_9ABC_DEF0);
        expect_at(1, K_PEND, 0, 0);
        expect_at(1, K_PEND, 1, 0);
        step();

        // Both slots rename the same GPR
        do_reset();
        alloc2(3, 3);
        expect_at(1, K_PDST, 0, 32); expect_at(1, K_PDST, 1, 33);
        expect_at(1, K_OLD, 0, 3);   expect_at(1, K_OLD, 1, 32);
        step();
        idle_in();
        rdmap_gpr[3] = 3;
        expect_at(1, K_PSRC, 3, 33); expect_at(1, K_PEND, 3, 1);
        step();

        // Drain the free list down to one entry, then reclaim via retire
        do_reset();
        for (int i = 0; i < 15; i++) begin
            idle_in();
            alloc2(5, 6);
            expect_at(0, K_STALL, 0, 0);
            expect_at(1, K_PDST, 0, 64'(32 + 2 * i));
            expect_at(1, K_PDST, 1, 64'(33 + 2 * i));
            step();
        end
        idle_in();
        alloc_en = 2'b01; alloc_gpr[0] = 5;
        expect_at(0, K_STALL, 0, 0);
        expect_at(1, K_PDST, 0, 62);
        step();
        idle_in();
        alloc2(5, 6);
        ret_en = 2'b01; ret_gpr[0] = 5; ret_pdst[0] = 32; ret_pdst_old[0] = 5;
        expect_at(0, K_STALL, 0, 1);
        step();
        idle_in();
        expect_at(0, K_STALL, 0, 0);
        alloc2(5, 6);
        expect_at(1, K_PDST, 0, 5);  expect_at(1, K_PDST, 1, 63);
        expect_at(1, K_OLD, 0, 62);  expect_at(1, K_OLD, 1, 61);
        step();
        idle_in();
        expect_at(0, K_STALL, 0, 1);
        step();

        // Flush recovery with a retire landing in the flush cycle
        do_reset();
        alloc_en = 2'b01; alloc_gpr[0] = 4;
        expect_at(1, K_PDST, 0, 32); expect_at(1, K_OLD, 0, 4);
        step();
        idle_in();
        alloc_en = 2'b01; alloc_gpr[0] = 4;
        expect_at(1, K_PDST, 0, 33); expect_at(1, K_OLD, 0, 32);
        step();
        idle_in();
        flush = 1'b1;
        ret_en = 2'b01; ret_gpr[0] = 4; ret_pdst[0] = 32; ret_pdst_old[0] = 4;
        alloc2(9, 10);
        expect_at(0, K_STALL, 0, 1);
        expect_at(1, K_RECOV, 0, 1);
        step();
        idle_in();
        alloc2(9, 10);
        rdmap_gpr[0] = 4;
        expect_at(0, K_STALL, 0, 1);
        expect_at(1, K_RECOV, 0, 0);
        expect_at(1, K_PSRC, 0, 32);
        expect_at(1, K_PEND, 0, 0);
        step();
        idle_in();
        expect_at(0, K_STALL, 0, 0);
        alloc2(8, 9);
        expect_at(1, K_PDST, 0, 4);  expect_at(1, K_PDST, 1, 33);
        expect_at(1, K_OLD, 0, 8);   expect_at(1, K_OLD, 1, 9);
        step();
        idle_in();
        rdmap_gpr[0] = 4; rdmap_gpr[1] = 8;
        expect_at(1, K_PSRC, 0, 32); expect_at(1, K_PEND, 0, 0);
        expect_at(1, K_PSRC, 1, 4);  expect_at(1, K_PEND, 1, 1);
        step();

        // Flush during RECOVER restarts it
        idle_in();
        flush = 1'b1;
        expect_at(1, K_RECOV, 0, 1);
        step();
        idle_in();
        flush = 1'b1;
        expect_at(0, K_STALL, 0, 1);
        expect_at(1, K_RECOV, 0, 1);
        step();
        idle_in();
        rdmap_gpr[2] = 8;
        expect_at(1, K_RECOV, 0, 0);
        expect_at(1, K_PSRC, 2, 8);
        step();
        idle_in();
        alloc_en = 2'b01; alloc_gpr[0] = 11;
        expect_at(1, K_PDST, 0, 4); expect_at(1, K_OLD, 0, 11);
        step();

`ifdef PRF_ZERO_REG_EN
        do_reset();
        alloc2(0, 7);
        expect_at(1, K_PDST, 0, 0);  expect_at(1, K_OLD, 0, 0);
        expect_at(1, K_PDST, 1, 32); expect_at(1, K_OLD, 1, 7);
        step();
        idle_in();
        wr_en[0] = 1'b1; wr_pdst[0] = 0; wr_data[0] = 64'h55;
        rd_psrc[0] = 0; rdmap_gpr[0] = 0;
        expect_at(1, K_RDD, 0, 0);
        expect_at(1, K_PSRC, 0, 0); expect_at(1, K_PEND, 0, 0);
        step();
        idle_in();
        rd_psrc[1] = 0;
        alloc_en = 2'b01; alloc_gpr[0] = 8;
        expect_at(1, K_RDD, 1, 0);
        expect_at(1, K_PDST, 0, 33);
        step();
`endif

        idle_in();
        for (int t = 0; t < 20 && sbq.size() > 0; t++) step();
        if (sbq.size() > 0) begin
            $display("FAIL drain pending=%0d want=0", sbq.size());
            bad += sbq.size();
            total += sbq.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
